// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART link codes, bit-timing defaults and state encodings
package uart_tx_pkg;

  localparam int CPB_W = 16;

  // Clocks per bit at 50 MHz; the top level exposes these as overridable parameters
  localparam int CPB_1200_DEF = 41667;
  localparam int CPB_2400_DEF = 20833;
  localparam int CPB_4800_DEF = 10417;
  localparam int CPB_9600_DEF = 5208;

  typedef logic [1:0] baud_t;
  localparam baud_t slowest   = 2'b00;
  localparam baud_t kindaSlow = 2'b01;
  localparam baud_t slow      = 2'b10;
  localparam baud_t normal    = 2'b11;

  // Code 2'b11 is deliberately unnamed: it means no parity, same as noParity
  typedef logic [1:0] parity_t;
  localparam parity_t noParity   = 2'b00;
  localparam parity_t oddParity  = 2'b01;
  localparam parity_t evenParity = 2'b10;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;

  function automatic logic parityOn(input parity_t p);
    return (p == oddParity) || (p == evenParity);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter; bitEnd marks the last cycle of each bit
module uart_bit_timer
  import uart_tx_pkg::*;
(
  input  logic             clkRx,
  input  logic             resetreg,
  input  logic             load,
  input  logic [CPB_W-1:0] cpbLoad,
  input  logic             enable,
  output logic             bitEnd
);

  localparam logic [CPB_W-1:0] ONE = 1;

  logic [CPB_W-1:0] cpbReg;
  logic [CPB_W-1:0] clkCount;

  assign bitEnd = enable && (clkCount == cpbReg - ONE);

  always_ff @(posedge clkRx or posedge resetreg) begin
    if (resetreg) begin
      cpbReg   <= '0;
      clkCount <= '0;
    end else if (load) begin
      cpbReg   <= cpbLoad;
      clkCount <= '0;
    end else if (enable) begin
      clkCount <= bitEnd ? '0 : clkCount + ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CPB_1200 = CPB_1200_DEF,
  parameter int CPB_2400 = CPB_2400_DEF,
  parameter int CPB_4800 = CPB_4800_DEF,
  parameter int CPB_9600 = CPB_9600_DEF
) (
  input  logic       clkRx,
  input  logic       resetreg,
  input  logic [1:0] baudRate,
  input  logic [1:0] parity,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       serialOutput,
  output logic       busy,
  output logic       done
);

  txState_t         state;
  txState_t         stateNext;
  logic [7:0]       dataReg;
  parity_t          parityMode;
  logic [2:0]       bitIndex;
  logic [CPB_W-1:0] cpbSel;
  logic             accept;
  logic             bitEnd;

  assign accept = (state == IDLE) && txStart;

  always_comb begin
    cpbSel = CPB_W'(CPB_9600);
    case (baudRate)
      slowest:   cpbSel = CPB_W'(CPB_1200);
      kindaSlow: cpbSel = CPB_W'(CPB_2400);
      slow:      cpbSel = CPB_W'(CPB_4800);
      default:   cpbSel = CPB_W'(CPB_9600);
    endcase
  end

  uart_bit_timer u_timer (
    .clkRx    (clkRx),
    .resetreg (resetreg),
    .load     (accept),
    .cpbLoad  (cpbSel),
    .enable   (state != IDLE),
    .bitEnd   (bitEnd)
  );

  always_ff @(posedge clkRx or posedge resetreg) begin
    if (resetreg) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (txStart) stateNext = START;
      START:   if (bitEnd) stateNext = DATA;
      DATA:    if (bitEnd && (bitIndex == 3'd7))
                 stateNext = parityOn(parityMode) ? PARITY : STOP;
      PARITY:  if (bitEnd) stateNext = STOP;
      STOP:    if (bitEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Frame configuration is captured only at accept so mid-frame input changes are inert
  always_ff @(posedge clkRx or posedge resetreg) begin
    if (resetreg) begin
      dataReg    <= '0;
      parityMode <= noParity;
      bitIndex   <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state == STOP) && bitEnd;
      if (accept) begin
        dataReg    <= txData;
        parityMode <= parity;
        bitIndex   <= '0;
      end else if ((state == DATA) && bitEnd) begin
        bitIndex <= bitIndex + 3'd1;
      end
    end
  end

  // Line is decoded from state so an asynchronous reset drives it high immediately
  always_comb begin
    serialOutput = 1'b1;
    busy         = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      START:   serialOutput = 1'b0;
      DATA:    serialOutput = dataReg[bitIndex];
      PARITY:  serialOutput = (parityMode == evenParity) ? ^dataReg : ~^dataReg;
      STOP:    serialOutput = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. Accepts one 8-bit byte per handshake and drives a framed serial line.
- Frame: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1).
- Baud rate and parity mode are selected with the same 2-bit codes the team's UART receiver uses, so one link is configured identically at both ends.
- Sits between the core's byte source and the serial pin, in the same clock domain as the receiver.

Parameters:
- CPB_1200, 41667, clocks per bit for the slowest rate (50 MHz clock)
- CPB_2400, 20833, clocks per bit for the kindaSlow rate
- CPB_4800, 10417, clocks per bit for the slow rate
- CPB_9600, 5208, clocks per bit for the normal rate

Ports:
- clkRx  in  1  system clock; all state updates on rising edge
- resetreg  in  1  asynchronous reset, active-high
- baudRate  in  2  00=1200, 01=2400, 10=4800, 11=9600
- parity  in  2  00=none, 01=odd, 10=even, 11=none
- txData  in  8  byte to send; sampled on accept
- txStart  in  1  request; accepted on a rising clkRx edge when busy=0
- serialOutput  out  1  serial line; idles high
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset values (asynchronous): serialOutput=1, busy=0, done=0, state=IDLE, counters=0, shift register=0.
- States: IDLE, START, DATA, PARITY, STOP.
- Bit timing: every bit is held exactly CPB cycles. The bit counter clkCount runs 0..CPB-1; the state advances when clkCount==CPB-1.
- IDLE:
  - serialOutput=1, busy=0.
  - On txStart=1 at edge k: latch txData, baudRate-derived CPB and parity mode; go to START.
  - From edge k: serialOutput=0 and busy=1. Latency from accept to start bit is 0 cycles after the accepting edge.
- START: after CPB cycles, go to DATA with bitIndex=0 and serialOutput=txData[0].
- DATA:
  - Output data[bitIndex] for CPB cycles; bitIndex increments 0..7.
  - After bit 7, go to PARITY if the latched mode is odd/even, otherwise to STOP.
- PARITY:
  - Even mode: output ^data, so total ones in data+parity is even.
  - Odd mode: output ~^data.
  - Hold for CPB cycles, then go to STOP.
- STOP:
  - Output 1 for CPB cycles.
  - At the final edge: go to IDLE, busy=0, done=1 for exactly that one cycle.
- Frame length: 10*CPB cycles without parity, 11*CPB cycles with parity.
- Configuration is latched at accept. Changes to baudRate, parity or txData mid-frame have no effect on the current frame.
- txStart while busy=1 is ignored; no queueing and no error flag.
- Back-to-back: txStart=1 in the done cycle (busy=0) is accepted at the next edge, so the start bit immediately follows the stop bit with no extra idle time beyond that cycle.
- Reset mid-frame: serialOutput returns to 1 immediately, state goes to IDLE, no done pulse. The partial frame is abandoned.
- Reset and txStart in the same cycle: reset wins.
- Parity code 11 behaves exactly as 00.

Decomposition:
- Shared package:
  - baud codes (slowest/kindaSlow/slow/normal)
  - parity codes (noParity/oddParity/evenParity)
  - CPB defaults
  - transmitter state encodings, alongside the receiver's existing ones
- One natural sub-module: uart_bit_timer.
  - Loads CPB at accept and asserts bitEnd when clkCount==CPB-1.
  - Reusable by the receiver for its mid-bit sampling.

Test Plan (simulation overrides CPB_1200=32, CPB_2400=16, CPB_4800=8, CPB_9600=4):
- baud=11, parity=00, txData=8'hA5, txStart pulse -> line 0, then 1,0,1,0,0,1,0,1, then 1; each bit 4 cycles; busy high 40 cycles; done pulses once at cycle 40.
- baud=10, parity=01, txData=8'h03 -> parity bit=1 (three ones total); frame 88 cycles.
- baud=10, parity=10, txData=8'h03 -> parity bit=0.
- txStart held continuously with bytes 8'h55 then 8'hFF -> second start bit begins one cycle after the first done; second frame correct; no bytes dropped beyond the handshake.
- Mid-frame: txStart during DATA, and baudRate changed 11->00 during DATA -> both ignored; frame completes at CPB=4.
- resetreg pulsed during DATA bit 3 of 8'h0F -> serialOutput=1 asynchronously, busy=0, no done pulse; next txStart transmits a clean full frame.
